// File: rtl/mfp_music_sequencer.sv
// Looping four-note square-wave bass line with a tempo set by the speed input.
// Optional silent gap between notes is enabled by defining MFP_MUSIC_GAP_EN.
module mfp_music_sequencer #(
  parameter int unsigned NOTE_LEN     = 12_500_000,
  parameter int unsigned SPEED_STEP   = 625_000,
  parameter int unsigned MIN_NOTE_LEN = 2_500_000,
  parameter int unsigned HALF0        = 454_545,
  parameter int unsigned HALF1        = 382_219,
  parameter int unsigned HALF2        = 340_507,
  parameter int unsigned HALF3        = 303_370,
  parameter int unsigned GAP_LEN      = 1_250_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       music_en,
  input  logic [3:0] speed,
  output logic       audio_out,
  output logic [1:0] note_idx,
  output logic       playing,
  output logic       note_strobe
);

  typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;

  state_e      state_q, state_d;
  logic [31:0] note_cnt_q, note_cnt_d;
  logic [31:0] tone_cnt_q, tone_cnt_d;
  logic        audio_q, audio_d;
  logic [1:0]  idx_q, idx_d;
  logic        playing_q, playing_d;
  logic        strobe_q, strobe_d;

  logic [31:0] step_prod;
  logic [31:0] note_len;
  logic [1:0]  idx_next;

  function automatic logic [31:0] half_len(input logic [1:0] idx);
    logic [31:0] h;
    unique case (idx)
      2'd0:    h = 32'(HALF0);
      2'd1:    h = 32'(HALF1);
      2'd2:    h = 32'(HALF2);
      default: h = 32'(HALF3);
    endcase
    return h;
  endfunction

  // Clamp before subtracting so a large speed can never wrap to a huge length.
  always_comb begin
    step_prod = 32'(speed) * 32'(SPEED_STEP);
    if (step_prod > 32'(NOTE_LEN) - 32'(MIN_NOTE_LEN)) begin
      note_len = 32'(MIN_NOTE_LEN);
    end else begin
      note_len = 32'(NOTE_LEN) - step_prod;
    end
    idx_next = idx_q + 2'd1;
  end

  always_comb begin
    state_d    = state_q;
    note_cnt_d = note_cnt_q;
    tone_cnt_d = tone_cnt_q;
    audio_d    = audio_q;
    idx_d      = idx_q;
    playing_d  = playing_q;
    strobe_d   = 1'b0;
    if (!music_en) begin
      state_d    = StIdle;
      note_cnt_d = '0;
      tone_cnt_d = '0;
      audio_d    = 1'b0;
      idx_d      = 2'd0;
      playing_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d    = StPlay;
          playing_d  = 1'b1;
          idx_d      = 2'd0;
          strobe_d   = 1'b1;
          audio_d    = 1'b0;
          note_cnt_d = note_len - 32'd1;
          tone_cnt_d = half_len(2'd0) - 32'd1;
        end
        StPlay: begin
          if (note_cnt_q == '0) begin
`ifdef MFP_MUSIC_GAP_EN
            state_d    = StGap;
            audio_d    = 1'b0;
            note_cnt_d = 32'(GAP_LEN) - 32'd1;
            tone_cnt_d = '0;
`else
            idx_d      = idx_next;
            strobe_d   = 1'b1;
            audio_d    = 1'b0;
            note_cnt_d = note_len - 32'd1;
            tone_cnt_d = half_len(idx_next) - 32'd1;
`endif
          end else begin
            note_cnt_d = note_cnt_q - 32'd1;
            if (tone_cnt_q == '0) begin
              audio_d    = ~audio_q;
              tone_cnt_d = half_len(idx_q) - 32'd1;
            end else begin
              tone_cnt_d = tone_cnt_q - 32'd1;
            end
          end
        end
        StGap: begin
          if (note_cnt_q == '0) begin
            state_d    = StPlay;
            idx_d      = idx_next;
            strobe_d   = 1'b1;
            note_cnt_d = note_len - 32'd1;
            tone_cnt_d = half_len(idx_next) - 32'd1;
          end else begin
            note_cnt_d = note_cnt_q - 32'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      note_cnt_q <= '0;
      tone_cnt_q <= '0;
      audio_q    <= 1'b0;
      idx_q      <= 2'd0;
      playing_q  <= 1'b0;
      strobe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      note_cnt_q <= note_cnt_d;
      tone_cnt_q <= tone_cnt_d;
      audio_q    <= audio_d;
      idx_q      <= idx_d;
      playing_q  <= playing_d;
      strobe_q   <= strobe_d;
    end
  end

  assign audio_out   = audio_q;
  assign note_idx    = idx_q;
  assign playing     = playing_q;
  assign note_strobe = strobe_q;

endmodule

// File: tb/tb_mfp_music_sequencer.sv
// Directed bench for mfp_music_sequencer using small test lengths; covers the
// MFP_MUSIC_GAP_EN build as well when that macro is defined.
module tb_mfp_music_sequencer;

`ifdef MFP_MUSIC_GAP_EN
  localparam bit GapEn = 1'b1;
`else
  localparam bit GapEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       music_en;
  logic [3:0] speed;
  logic       audio_out;
  logic [1:0] note_idx;
  logic       playing;
  logic       note_strobe;

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;

  // Reference: 0 idle, 1 play, 2 gap; offset counts cycles since phase start
  int m_state = 0;
  int m_idx   = 0;
  int m_off   = 0;
  int m_len   = 0;

  mfp_music_sequencer #(
    .NOTE_LEN    (20),
    .SPEED_STEP  (4),
    .MIN_NOTE_LEN(8),
    .HALF0       (2),
    .HALF1       (3),
    .HALF2       (4),
    .HALF3       (5),
    .GAP_LEN     (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .music_en   (music_en),
    .speed      (speed),
    .audio_out  (audio_out),
    .note_idx   (note_idx),
    .playing    (playing),
    .note_strobe(note_strobe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int len_of(input int s);
    return (s * 4 > 12) ? 8 : 20 - 4 * s;
  endfunction

  function automatic logic [31:0] expv();
    logic a;
    logic [1:0] ix;
    ix = 2'(m_idx);
    a  = ((m_off / (m_idx + 2)) % 2) == 1;
    if (m_state == 1) return {27'd0, a, ix, 1'b1, m_off == 0};
    if (m_state == 2) return {27'd0, 1'b0, ix, 1'b1, 1'b0};
    return 32'd0;
  endfunction

  // Advance the reference over the coming posedge, using current inputs.
  task automatic model_step();
    if (!music_en) begin
      m_state = 0;
    end else if (m_state == 0) begin
      m_state = 1; m_idx = 0; m_off = 0; m_len = len_of(int'(speed));
    end else if (m_state == 1) begin
      m_off++;
      if (m_off == m_len) begin
        m_off = 0;
        if (GapEn) begin
          m_state = 2;
        end else begin
          m_idx = (m_idx + 1) % 4; m_len = len_of(int'(speed));
        end
      end
    end else begin
      m_off++;
      if (m_off == 4) begin
        m_state = 1; m_off = 0; m_idx = (m_idx + 1) % 4; m_len = len_of(int'(speed));
      end
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      model_step();
      @(negedge clk);
      check($sformatf("cyc%0d st%0d idx%0d off%0d", ncyc, m_state, m_idx, m_off),
            {27'd0, audio_out, note_idx, playing, note_strobe}, expv());
      ncyc++;
    end
  endtask

  initial begin
    reset    = 1'b1;
    music_en = 1'b0;
    speed    = 4'd0;
    #1;
    check("reset_outs", {27'd0, audio_out, note_idx, playing, note_strobe}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cyc(100);

    // Slowest tempo through a full loop of four notes and back to note 0
    music_en = 1'b1;
    cyc(100);

    // 8-cycle notes, then clamp on an oversized speed
    music_en = 1'b0;
    cyc(2);
    speed    = 4'd3;
    music_en = 1'b1;
    cyc(40);
    speed = 4'd15;
    cyc(40);

    // Speed change mid-note only affects the following note
    music_en = 1'b0;
    speed    = 4'd0;
    cyc(2);
    music_en = 1'b1;
    cyc(10);
    speed = 4'd3;
    cyc(40);

    // Enable drop mid-note1, then restart from note 0
    speed    = 4'd0;
    music_en = 1'b0;
    cyc(2);
    music_en = 1'b1;
    cyc(25);
    music_en = 1'b0;
    cyc(3);
    music_en = 1'b1;
    cyc(5);

    // Asynchronous reset between clock edges
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", {27'd0, audio_out, note_idx, playing, note_strobe}, 32'd0);
    m_state = 0;
    @(negedge clk);
    check("held_reset", {27'd0, audio_out, note_idx, playing, note_strobe}, 32'd0);
    reset = 1'b0;
    cyc(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
